// File: rtl/debug_trace_ctrl.sv
// Run-control FSM (halt/run/step) with PC breakpoints, exception stop and a circular trace buffer.
// Define DBG_TIMESTAMP_EN to prepend a 16-bit cpu_en-cycle timestamp to every trace entry.
module debug_trace_ctrl #(
  parameter int unsigned PC_W  = 32,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned NBKPT = 2,
`ifdef DBG_TIMESTAMP_EN
  localparam int unsigned TW = PC_W + 48,
`else
  localparam int unsigned TW = PC_W + 32,
`endif
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [7:0]            step_cnt,
  input  logic [NBKPT*PC_W-1:0] bkpt_addr,
  input  logic [NBKPT-1:0]      bkpt_en,
  input  logic [PC_W-1:0]       pc,
  input  logic [31:0]           x31,
  input  logic [4:0]            scause,
  output logic                  cpu_en,
  output logic                  halted,
  output logic [1:0]            halt_reason,
  output logic                  cmd_err,
  input  logic                  trace_rd,
  output logic [TW-1:0]         trace_data,
  output logic                  trace_valid,
  output logic [CW-1:0]         trace_count,
  output logic                  trace_ovf
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {ST_HALT, ST_RUN, ST_STEP} state_t;
  typedef enum logic [1:0] {OP_RUN, OP_STEP, OP_HALT, OP_CLEAR} op_t;

  state_t          state;
  op_t             op;
  logic [7:0]      step_left;
  logic            resume_q;
  logic            bkpt_raw;
  logic            bkpt_hit;
  logic            exc;
  logic            cmd_fire;
  logic            clear_fire;
  logic            push;
  logic            pop;
  logic            full;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            ovf_q;
  logic [TW-1:0]   entry;
  logic [TW-1:0]   mem [DEPTH];

  assign cmd_ready  = 1'b1;
  assign cmd_fire   = cmd_valid && cmd_ready;
  assign op         = op_t'(cmd_op);
  assign clear_fire = cmd_fire && (op == OP_CLEAR) && (state == ST_HALT);

  always_comb begin
    bkpt_raw = 1'b0;
    for (int unsigned i = 0; i < NBKPT; i++) begin
      if (bkpt_en[i] && (bkpt_addr[i*PC_W +: PC_W] == pc)) bkpt_raw = 1'b1;
    end
  end

  // The first cycle after resuming ignores breakpoints so a halt on a breakpoint PC can step over it.
  assign bkpt_hit = bkpt_raw && !resume_q;
  assign exc      = (scause != 5'd0);
  assign cpu_en   = (state != ST_HALT) && !bkpt_hit && !exc;
  assign halted   = (state == ST_HALT);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_HALT;
      halt_reason <= 2'd0;
      step_left   <= '0;
      cmd_err     <= 1'b0;
      resume_q    <= 1'b0;
    end else begin
      cmd_err  <= 1'b0;
      resume_q <= 1'b0;
      case (state)
        ST_HALT: begin
          if (cmd_fire) begin
            case (op)
              OP_RUN: begin
                state       <= ST_RUN;
                halt_reason <= 2'd0;
                resume_q    <= 1'b1;
              end
              OP_STEP: begin
                state       <= ST_STEP;
                halt_reason <= 2'd0;
                resume_q    <= 1'b1;
                step_left   <= (step_cnt == 8'd0) ? 8'd1 : step_cnt;
              end
              default: ;
            endcase
          end
        end
        ST_RUN, ST_STEP: begin
          if ((state == ST_STEP) && cpu_en) step_left <= step_left - 8'd1;
          if (exc) begin
            state       <= ST_HALT;
            halt_reason <= 2'd3;
          end else if (bkpt_hit) begin
            state       <= ST_HALT;
            halt_reason <= 2'd2;
          end else if ((state == ST_STEP) && cpu_en && (step_left == 8'd1)) begin
            state       <= ST_HALT;
            halt_reason <= 2'd1;
          end else if (cmd_fire && (op == OP_HALT)) begin
            state       <= ST_HALT;
            halt_reason <= 2'd0;
          end
          if (cmd_fire && (op != OP_HALT)) cmd_err <= 1'b1;
        end
        default: state <= ST_HALT;
      endcase
    end
  end

  assign push = cpu_en;
  assign pop  = trace_rd && (count != '0);
  assign full = (count == CW'(DEPTH));

`ifdef DBG_TIMESTAMP_EN
  logic [15:0] ts;

  always_ff @(posedge clk) begin
    if (!rst) ts <= '0;
    else if (push) ts <= ts + 16'd1;
  end

  assign entry = {ts, pc, x31};
`else
  assign entry = {pc, x31};
`endif

  // When full, a push advances the read pointer too so the oldest entry is the one overwritten.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
    end else if (clear_fire) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop || (push && full)) rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop && !full) count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      if (push && full && !pop) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push) mem[wr_ptr] <= entry;
  end

  assign trace_data  = mem[rd_ptr];
  assign trace_valid = (count != '0);
  assign trace_count = count;
  assign trace_ovf   = ovf_q;

endmodule

// File: tb/tb_debug_trace_ctrl.sv
// Directed bench for debug_trace_ctrl: a tiny CPU model advances pc by 4 and x31 by 1 on each cpu_en cycle.
module tb_debug_trace_ctrl;

  localparam int unsigned PC_W  = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned NBKPT = 2;
`ifdef DBG_TIMESTAMP_EN
  localparam int unsigned TW = PC_W + 48;
`else
  localparam int unsigned TW = PC_W + 32;
`endif
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  localparam logic [1:0] C_RUN   = 2'b00;
  localparam logic [1:0] C_STEP  = 2'b01;
  localparam logic [1:0] C_HALT  = 2'b10;
  localparam logic [1:0] C_CLEAR = 2'b11;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_op;
  logic [7:0]            step_cnt;
  logic [NBKPT*PC_W-1:0] bkpt_addr;
  logic [NBKPT-1:0]      bkpt_en;
  logic [PC_W-1:0]       pc;
  logic [31:0]           x31;
  logic [4:0]            scause;
  logic                  cpu_en;
  logic                  halted;
  logic [1:0]            halt_reason;
  logic                  cmd_err;
  logic                  trace_rd;
  logic [TW-1:0]         trace_data;
  logic                  trace_valid;
  logic [CW-1:0]         trace_count;
  logic                  trace_ovf;

  int n_cmp = 0;
  int n_bad = 0;
  int en_cnt = 0;
  logic [PC_W-1:0] exc_pc = '1;

  debug_trace_ctrl #(.PC_W(PC_W), .DEPTH(DEPTH), .NBKPT(NBKPT)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .step_cnt(step_cnt), .bkpt_addr(bkpt_addr), .bkpt_en(bkpt_en),
    .pc(pc), .x31(x31), .scause(scause), .cpu_en(cpu_en), .halted(halted),
    .halt_reason(halt_reason), .cmd_err(cmd_err), .trace_rd(trace_rd),
    .trace_data(trace_data), .trace_valid(trace_valid), .trace_count(trace_count),
    .trace_ovf(trace_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cycle();
    logic en;
    @(negedge clk);
    en = cpu_en;
    @(posedge clk);
    #1;
    if (en) begin
      pc = pc + 32'd4;
      x31 = x31 + 32'd1;
      en_cnt++;
    end
    scause = (pc == exc_pc) ? 5'd5 : 5'd0;
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [7:0] sc);
    cmd_valid = 1'b1;
    cmd_op = op;
    step_cnt = sc;
    cycle();
    cmd_valid = 1'b0;
  endtask

  task automatic pop_one();
    trace_rd = 1'b1;
    cycle();
    trace_rd = 1'b0;
  endtask

  task automatic wait_halt(input int budget);
    for (int i = 0; i < budget && !halted; i++) cycle();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cmd_valid = 1'b1;
    cmd_op = C_RUN;
    cycle();
    cycle();
    cmd_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL rst_halted: got %b want 1", halted); end
    n_cmp++; if (halt_reason !== 2'd0) begin n_bad++; $display("FAIL rst_reason: got %0d want 0", halt_reason); end
    n_cmp++; if (cpu_en !== 1'b0) begin n_bad++; $display("FAIL rst_cpu_en: got %b want 0", cpu_en); end
    n_cmp++; if (trace_count !== '0) begin n_bad++; $display("FAIL rst_count: got %0d want 0", trace_count); end
    n_cmp++; if (trace_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", trace_valid); end
    n_cmp++; if (trace_ovf !== 1'b0) begin n_bad++; $display("FAIL rst_ovf: got %b want 0", trace_ovf); end
    n_cmp++; if (cmd_err !== 1'b0) begin n_bad++; $display("FAIL rst_cmd_err: got %b want 0", cmd_err); end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_step();
    pc = '0;
    x31 = '0;
    en_cnt = 0;
    do_cmd(C_STEP, 8'd3);
    n_cmp++; if (halt_reason !== 2'd0) begin n_bad++; $display("FAIL step_reason_running: got %0d want 0", halt_reason); end
    wait_halt(20);
    n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL step_halt_timeout: got %b want 1", halted); end
    n_cmp++; if (en_cnt !== 3) begin n_bad++; $display("FAIL step_en_cycles: got %0d want 3", en_cnt); end
    n_cmp++; if (halt_reason !== 2'd1) begin n_bad++; $display("FAIL step_reason: got %0d want 1", halt_reason); end
    n_cmp++; if (trace_count !== CW'(3)) begin n_bad++; $display("FAIL step_count: got %0d want 3", trace_count); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (trace_data[PC_W+31:32] !== PC_W'(4 * i)) begin n_bad++; $display("FAIL step_pc%0d: got %0h want %0h", i, trace_data[PC_W+31:32], 4 * i); end
      n_cmp++; if (trace_data[31:0] !== 32'(i)) begin n_bad++; $display("FAIL step_x31_%0d: got %0h want %0h", i, trace_data[31:0], i); end
`ifdef DBG_TIMESTAMP_EN
      n_cmp++; if (trace_data[TW-1 -: 16] !== 16'(i)) begin n_bad++; $display("FAIL step_ts%0d: got %0d want %0d", i, trace_data[TW-1 -: 16], i); end
`endif
      pop_one();
    end
    n_cmp++; if (trace_valid !== 1'b0) begin n_bad++; $display("FAIL step_drained: got %b want 0", trace_valid); end
    en_cnt = 0;
    do_cmd(C_STEP, 8'd0);
    wait_halt(20);
    n_cmp++; if (en_cnt !== 1) begin n_bad++; $display("FAIL step0_en_cycles: got %0d want 1", en_cnt); end
    n_cmp++; if (halt_reason !== 2'd1) begin n_bad++; $display("FAIL step0_reason: got %0d want 1", halt_reason); end
  endtask

  task automatic test_breakpoint();
    do_cmd(C_CLEAR, 8'd0);
    n_cmp++; if (trace_count !== '0) begin n_bad++; $display("FAIL bk_clear: got %0d want 0", trace_count); end
    pc = '0;
    bkpt_addr = {32'h0, 32'h10};
    bkpt_en = 2'b01;
    do_cmd(C_RUN, 8'd0);
    wait_halt(20);
    n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL bk_halt_timeout: got %b want 1", halted); end
    n_cmp++; if (halt_reason !== 2'd2) begin n_bad++; $display("FAIL bk_reason: got %0d want 2", halt_reason); end
    n_cmp++; if (pc !== 32'h10) begin n_bad++; $display("FAIL bk_pc_not_executed: got %0h want 10", pc); end
    n_cmp++; if (trace_count !== CW'(4)) begin n_bad++; $display("FAIL bk_count: got %0d want 4", trace_count); end
    for (int i = 0; i < 3; i++) pop_one();
    n_cmp++; if (trace_data[PC_W+31:32] !== 32'h0C) begin n_bad++; $display("FAIL bk_last_pc: got %0h want c", trace_data[PC_W+31:32]); end
    do_cmd(C_RUN, 8'd0);
    repeat (5) cycle();
    n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL bk_resume_halted: got %b want 0", halted); end
    n_cmp++; if (halt_reason !== 2'd0) begin n_bad++; $display("FAIL bk_resume_reason: got %0d want 0", halt_reason); end
    n_cmp++; if (pc !== 32'h24) begin n_bad++; $display("FAIL bk_resume_pc: got %0h want 24", pc); end
    do_cmd(C_HALT, 8'd0);
    n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL halt_cmd_halted: got %b want 1", halted); end
    n_cmp++; if (halt_reason !== 2'd0) begin n_bad++; $display("FAIL halt_cmd_reason: got %0d want 0", halt_reason); end
    bkpt_en = 2'b00;
  endtask

  task automatic test_exception();
    do_cmd(C_CLEAR, 8'd0);
    pc = 32'h18;
    bkpt_addr = {32'h20, 32'h0};
    bkpt_en = 2'b10;
    exc_pc = 32'h20;
    do_cmd(C_RUN, 8'd0);
    wait_halt(20);
    n_cmp++; if (halt_reason !== 2'd3) begin n_bad++; $display("FAIL exc_reason: got %0d want 3", halt_reason); end
    n_cmp++; if (pc !== 32'h20) begin n_bad++; $display("FAIL exc_pc: got %0h want 20", pc); end
    n_cmp++; if (trace_count !== CW'(2)) begin n_bad++; $display("FAIL exc_count: got %0d want 2", trace_count); end
    exc_pc = '1;
    scause = 5'd0;
    bkpt_en = 2'b00;
  endtask

  task automatic test_overflow();
    do_cmd(C_CLEAR, 8'd0);
    pc = 32'h100;
    x31 = '0;
    do_cmd(C_RUN, 8'd0);
    repeat (19) cycle();
    do_cmd(C_HALT, 8'd0);
    n_cmp++; if (trace_count !== CW'(16)) begin n_bad++; $display("FAIL ovf_count: got %0d want 16", trace_count); end
    n_cmp++; if (trace_ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_flag: got %b want 1", trace_ovf); end
    n_cmp++; if (trace_data[PC_W+31:32] !== 32'h110) begin n_bad++; $display("FAIL ovf_oldest_pc: got %0h want 110", trace_data[PC_W+31:32]); end
    trace_rd = 1'b1;
    do_cmd(C_CLEAR, 8'd0);
    trace_rd = 1'b0;
    n_cmp++; if (trace_count !== '0) begin n_bad++; $display("FAIL clr_count: got %0d want 0", trace_count); end
    n_cmp++; if (trace_ovf !== 1'b0) begin n_bad++; $display("FAIL clr_ovf: got %b want 0", trace_ovf); end
    pop_one();
    n_cmp++; if (trace_count !== '0) begin n_bad++; $display("FAIL empty_pop_count: got %0d want 0", trace_count); end
    do_cmd(C_HALT, 8'd0);
    cycle();
    n_cmp++; if (cmd_err !== 1'b0) begin n_bad++; $display("FAIL halt_in_halt_err: got %b want 0", cmd_err); end
    n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL halt_in_halt_state: got %b want 1", halted); end
  endtask

  task automatic test_cmd_err();
    pc = 32'h200;
    do_cmd(C_RUN, 8'd0);
    repeat (3) cycle();
    do_cmd(C_CLEAR, 8'd0);
    n_cmp++; if (cmd_err !== 1'b1) begin n_bad++; $display("FAIL err_pulse: got %b want 1", cmd_err); end
    n_cmp++; if (trace_count !== CW'(4)) begin n_bad++; $display("FAIL err_trace_intact: got %0d want 4", trace_count); end
    n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL err_still_running: got %b want 0", halted); end
    cycle();
    n_cmp++; if (cmd_err !== 1'b0) begin n_bad++; $display("FAIL err_one_cycle: got %b want 0", cmd_err); end
    for (int i = 0; i < 40 && trace_count != CW'(16); i++) cycle();
    n_cmp++; if (trace_count !== CW'(16)) begin n_bad++; $display("FAIL full_count: got %0d want 16", trace_count); end
    n_cmp++; if (trace_ovf !== 1'b0) begin n_bad++; $display("FAIL full_no_ovf: got %b want 0", trace_ovf); end
    pop_one();
    n_cmp++; if (trace_count !== CW'(16)) begin n_bad++; $display("FAIL pushpop_count: got %0d want 16", trace_count); end
    n_cmp++; if (trace_ovf !== 1'b0) begin n_bad++; $display("FAIL pushpop_ovf: got %b want 0", trace_ovf); end
    n_cmp++; if (trace_data[PC_W+31:32] !== 32'h204) begin n_bad++; $display("FAIL pushpop_oldest: got %0h want 204", trace_data[PC_W+31:32]); end
    do_cmd(C_HALT, 8'd0);
    n_cmp++; if (trace_ovf !== 1'b1) begin n_bad++; $display("FAIL full_push_ovf: got %b want 1", trace_ovf); end
  endtask

  task automatic test_reset_mid_run();
    do_cmd(C_RUN, 8'd0);
    repeat (2) cycle();
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL midrst_halted: got %b want 1", halted); end
    n_cmp++; if (cpu_en !== 1'b0) begin n_bad++; $display("FAIL midrst_cpu_en: got %b want 0", cpu_en); end
    n_cmp++; if (trace_count !== '0) begin n_bad++; $display("FAIL midrst_count: got %0d want 0", trace_count); end
    n_cmp++; if (trace_ovf !== 1'b0) begin n_bad++; $display("FAIL midrst_ovf: got %b want 0", trace_ovf); end
  endtask

  initial begin
    rst = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = C_HALT;
    step_cnt = '0;
    bkpt_addr = '0;
    bkpt_en = '0;
    pc = '0;
    x31 = '0;
    scause = '0;
    trace_rd = 1'b0;
    test_reset();
    test_step();
    test_breakpoint();
    test_exception();
    test_overflow();
    test_cmd_err();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
